// File: rtl/iter_multiplier_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide units:
// bus widths, zero constants, booleans and the 2-bit FSM state encodings.
package iter_multiplier_pkg;

    localparam int DataBus = 32;
    localparam int DWord   = 64;

    localparam logic [DataBus-1:0] ZeroWord  = '0;
    localparam logic [DWord-1:0]   ZeroDWord = '0;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    // multiplier states
    localparam logic [1:0] MulFree = 2'b00;
    localparam logic [1:0] MulOn   = 2'b01;
    localparam logic [1:0] MulEnd  = 2'b10;

    // divider states (companion unit)
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    // Magnitude of a 32-bit operand; 0x80000000 stays exact as unsigned.
    function automatic logic [DataBus-1:0] mag(
        input logic [DataBus-1:0] x,
        input logic               sm
    );
        return (sm & x[DataBus-1]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/iter_multiplier_if.sv
// Handshake bundle between the EX muldiv control (master) and the multiplier (slave).
// Ports: start/abandon/stall/signmul/opr1/opr2 toward the unit; ready/res back.
interface iter_multiplier_if;
    import iter_multiplier_pkg::*;

    logic               start;
    logic               abandon;
    logic               stall;
    logic               signmul;
    logic [DataBus-1:0] opr1;
    logic [DataBus-1:0] opr2;
    logic               ready;
    logic [DWord-1:0]   res;

    modport master (
        output start, abandon, stall, signmul, opr1, opr2,
        input  ready, res
    );

    modport slave (
        input  start, abandon, stall, signmul, opr1, opr2,
        output ready, res
    );

endinterface

// File: rtl/iter_multiplier_step.sv
// One shift-add iteration: adds mcand * (low STEP_BITS of product) into the high half
// and shifts the whole product right by STEP_BITS.
// Ports: mcand (32), product (64) in; prod_next (64) out. Purely combinational.
import iter_multiplier_pkg::*;

module mul_step #(
    parameter int STEP_BITS = 1
) (
    input  logic [DataBus-1:0] mcand,
    input  logic [DWord-1:0]   product,
    output logic [DWord-1:0]   prod_next
);

    localparam int W = DataBus + STEP_BITS;

    logic [W-1:0] hi;
    logic [W-1:0] mc;
    logic [W-1:0] digit;
    logic [W-1:0] sum;

    assign hi    = W'(product[DWord-1:DataBus]);
    assign mc    = W'(mcand);
    assign digit = W'(product[STEP_BITS-1:0]);

    // (2^32-1)*(2^S-1) + (2^32-1) < 2^(32+S): no carry is lost
    assign sum = hi + mc * digit;

    assign prod_next = {sum, product[DataBus-1:STEP_BITS]};

endmodule

// File: rtl/iter_multiplier.sv
// Iterative shift-add 32x32->64 multiplier, signed or unsigned, STEP_BITS bits per cycle.
// Ports: clk, rst (async, active-high); bus (slave): start/abandon/stall/signmul/opr1/opr2 in,
// ready/res out, res = {HI, LO}.
import iter_multiplier_pkg::*;

module iter_multiplier #(
    parameter int STEP_BITS = 1
) (
    input logic              clk,
    input logic              rst,
    iter_multiplier_if.slave bus
);

    localparam int         N       = DataBus / STEP_BITS;
    localparam logic [5:0] LastCnt = 6'(N);

    logic [1:0]         state;
    logic [DataBus-1:0] mcand;
    logic [DWord-1:0]   product;
    logic [DWord-1:0]   prod_next;
    logic [5:0]         cnt;
    logic               neg;
    logic               ready;
    logic [DWord-1:0]   res;
    logic [DataBus-1:0] abs1;
    logic [DataBus-1:0] abs2;
    logic               zero_op;

    assign abs1    = mag(bus.opr1, bus.signmul);
    assign abs2    = mag(bus.opr2, bus.signmul);
    assign zero_op = (bus.opr1 == ZeroWord) || (bus.opr2 == ZeroWord);

    mul_step #(
        .STEP_BITS(STEP_BITS)
    ) u_step (
        .mcand    (mcand),
        .product  (product),
        .prod_next(prod_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MulFree;
            ready   <= False;
            res     <= ZeroDWord;
            product <= ZeroDWord;
            mcand   <= ZeroWord;
            cnt     <= '0;
            neg     <= False;
        end else if (bus.abandon) begin
            state   <= MulFree;
            ready   <= False;
            res     <= ZeroDWord;
            product <= ZeroDWord;
            mcand   <= ZeroWord;
            cnt     <= '0;
            neg     <= False;
        end else begin
            unique case (state)
                MulFree: begin
                    if (bus.start) begin
                        mcand <= abs1;
                        neg   <= bus.signmul & (bus.opr1[31] ^ bus.opr2[31]);
                        state <= MulOn;
                        // zero operand: skip iterations, keep the fix-up cycle
                        if (zero_op) begin
                            product <= ZeroDWord;
                            cnt     <= LastCnt;
                        end else begin
                            product <= {ZeroWord, abs2};
                            cnt     <= '0;
                        end
                    end else begin
                        ready <= False;
                        res   <= ZeroDWord;
                    end
                end
                MulOn: begin
                    if (cnt != LastCnt) begin
                        product <= prod_next;
                        cnt     <= cnt + 6'd1;
                    end else begin
                        if (neg) begin
                            product <= ~product + 64'd1;
                        end
                        cnt   <= '0;
                        state <= MulEnd;
                    end
                end
                MulEnd: begin
                    if (!bus.start && !bus.stall) begin
                        state <= MulFree;
                        ready <= False;
                        res   <= ZeroDWord;
                    end else begin
                        res   <= product;
                        ready <= True;
                    end
                end
                default: begin
                    state <= MulFree;
                end
            endcase
        end
    end

    assign bus.ready = ready;
    assign bus.res   = res;

endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier at STEP_BITS = 1, 2 and 4 in lock-step.
// Directed cases, abandon, stall, async reset and random operands against a reference model.
module tb_iter_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abandon;
    logic        stall;
    logic        signmul;
    logic [31:0] opr1;
    logic [31:0] opr2;

    logic        rdy [3];
    logic [63:0] rs  [3];

    int passed = 0;
    int total  = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    iter_multiplier_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].start   = start;
        assign bus[g].abandon = abandon;
        assign bus[g].stall   = stall;
        assign bus[g].signmul = signmul;
        assign bus[g].opr1    = opr1;
        assign bus[g].opr2    = opr2;
        assign rdy[g]         = bus[g].ready;
        assign rs[g]          = bus[g].res;

        iter_multiplier #(
            .STEP_BITS(1 << g)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want)
            $display("FAIL %s: got %h, want %h", tag, got, want);
        else
            passed++;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sm);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sm) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Launch an operation, wait for every DUT's ready, compare result and latency.
    // start is left high; the caller decides how the result is released.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm);
        int          lat [3];
        logic [63:0] got [3];
        logic [63:0] want;
        int          nexp;
        bit          zero;
        zero = (a == 0) || (b == 0);
        exp_q.push_back(model(a, b, sm));
        opr1    = a;
        opr2    = b;
        signmul = sm;
        start   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1;
            got[k] = '0;
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                opr1 = $urandom;
                opr2 = $urandom;
            end
            for (int k = 0; k < 3; k++)
                if (rdy[k] && lat[k] < 0) begin
                    lat[k] = c - 1;
                    got[k] = rs[k];
                end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        want = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            nexp = zero ? 2 : (32 >> k) + 2;
            check($sformatf("res s%0d %h*%h sm%0d", 1 << k, a, b, sm), got[k], want);
            check($sformatf("lat s%0d", 1 << k), 64'(lat[k]), 64'(nexp));
        end
    endtask

    task automatic release_op();
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rel ready s%0d", 1 << k), 64'(rdy[k]), 64'd0);
            check($sformatf("rel res s%0d", 1 << k), rs[k], 64'd0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abandon = 1'b0;
        stall   = 1'b0;
        signmul = 1'b0;
        opr1    = '0;
        opr2    = '0;
        repeat (2) @(negedge clk);
        check("reset ready", 64'(rdy[0]), 64'd0);
        check("reset res", rs[0], 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        release_op();
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1);
        release_op();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        release_op();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        release_op();
        run_op(32'h1234_5678, 32'd0, 1'b1);
        release_op();
        run_op(32'd0, 32'hFFFF_FFFF, 1'b1);
        release_op();

        // abandon mid-iteration, then a fresh request
        opr1    = 32'h0001_2345;
        opr2    = 32'h0006_789A;
        signmul = 1'b0;
        start   = 1'b1;
        repeat (11) @(negedge clk);
        abandon = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        abandon = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("abandon ready s%0d", 1 << k), 64'(rdy[k]), 64'd0);
        check("abandon res", rs[0], 64'd0);
        run_op(32'd5, 32'd6, 1'b0);
        release_op();

        // stall holds the result after start drops
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        stall = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall ready", 64'(rdy[0]), 64'd1);
            check("stall res", rs[0], model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1));
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall ready", 64'(rdy[0]), 64'd0);
        check("unstall res", rs[0], 64'd0);

        // async reset while one unit is done and others still iterate
        opr1    = 32'd1000;
        opr2    = 32'd3;
        signmul = 1'b0;
        start   = 1'b1;
        repeat (12) @(negedge clk);
        check("pre-rst ready s4", 64'(rdy[2]), 64'd1);
        rst = 1'b1;
        #1;
        check("async rst ready s4", 64'(rdy[2]), 64'd0);
        check("async rst res s4", rs[2], 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i == 3) a = 32'h8000_0000;
            if (i == 5) b = 32'h0000_0001;
            run_op(a, b, 1'(i % 2));
            release_op();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
